cg_idle_ctrl: RTL

CG_IDLE_CTRL -- requirements
Module: cg_idle_ctrl

---
 rtl/cg_idle_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/cg_idle_ctrl.sv
// Per-domain idle-detect clock-gate controller: RUN -> IDLE_CNT -> GATED -> WAKE -> RUN.
// Define CG_IDLE_CTRL_STATS_EN to add the GATE_EVT_CNT gating-event counter output.
module cg_idle_ctrl #(
  parameter int unsigned N_DOM       = 4,
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned WAKE_LAT    = 2
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             CG_DIS,
  input  logic [N_DOM-1:0] BUSY,
  input  logic [N_DOM-1:0] WAKE_REQ,
  output logic [N_DOM-1:0] E,
  output logic [N_DOM-1:0] WAKE_ACK,
  output logic [N_DOM-1:0] GATED
`ifdef CG_IDLE_CTRL_STATS_EN
  ,
  output logic [15:0]      GATE_EVT_CNT
`endif
);

  typedef enum logic [1:0] {S_RUN, S_IDLE_CNT, S_GATED, S_WAKE} state_e;

  localparam logic [7:0] IDLE_LOAD = 8'(IDLE_CYCLES - 1);
  localparam logic [3:0] WAKE_LOAD = 4'(WAKE_LAT - 1);

  state_e           state_q [N_DOM];
  state_e           state_d [N_DOM];
  logic [7:0]       cnt_q   [N_DOM];
  logic [7:0]       cnt_d   [N_DOM];
  logic [3:0]       wcnt_q  [N_DOM];
  logic [3:0]       wcnt_d  [N_DOM];
  logic [N_DOM-1:0] e_q, e_d;
  logic [N_DOM-1:0] ack_q, ack_d;
  logic [N_DOM-1:0] gated_q, gated_d;

  always_ff @(posedge CK) begin
    if (RST) begin
      for (int unsigned d = 0; d < N_DOM; d++) begin
        state_q[d] <= S_RUN;
        cnt_q[d]   <= '0;
        wcnt_q[d]  <= '0;
      end
      e_q     <= '1;
      ack_q   <= '0;
      gated_q <= '0;
    end else begin
      for (int unsigned d = 0; d < N_DOM; d++) begin
        state_q[d] <= state_d[d];
        cnt_q[d]   <= cnt_d[d];
        wcnt_q[d]  <= wcnt_d[d];
      end
      e_q     <= e_d;
      ack_q   <= ack_d;
      gated_q <= gated_d;
    end
  end

  always_comb begin
    for (int unsigned d = 0; d < N_DOM; d++) begin
      state_d[d] = state_q[d];
      cnt_d[d]   = cnt_q[d];
      wcnt_d[d]  = wcnt_q[d];
      unique case (state_q[d])
        S_RUN: begin
          if (!CG_DIS && !BUSY[d] && !WAKE_REQ[d]) begin
            state_d[d] = S_IDLE_CNT;
            cnt_d[d]   = IDLE_LOAD;
          end
        end
        S_IDLE_CNT: begin
          if (CG_DIS || BUSY[d] || WAKE_REQ[d]) begin
            state_d[d] = S_RUN;
          end else if (cnt_q[d] == '0) begin
            state_d[d] = S_GATED;
          end else begin
            cnt_d[d] = cnt_q[d] - 8'd1;
          end
        end
        S_GATED: begin
          // CG_DIS bypasses WAKE entirely, so no acknowledge is produced.
          if (CG_DIS) begin
            state_d[d] = S_RUN;
          end else if (BUSY[d] || WAKE_REQ[d]) begin
            state_d[d] = S_WAKE;
            wcnt_d[d]  = WAKE_LOAD;
          end
        end
        S_WAKE: begin
          if (wcnt_q[d] == '0) begin
            state_d[d] = S_RUN;
          end else begin
            wcnt_d[d] = wcnt_q[d] - 4'd1;
          end
        end
        default: state_d[d] = S_RUN;
      endcase
    end
  end

  // Outputs are flopped from the next state so they always match state_q.
  always_comb begin
    e_d     = '1;
    gated_d = '0;
    ack_d   = '0;
    for (int unsigned d = 0; d < N_DOM; d++) begin
      e_d[d]     = (state_d[d] != S_GATED);
      gated_d[d] = (state_d[d] == S_GATED);
      ack_d[d]   = (state_q[d] == S_WAKE) && (state_d[d] == S_RUN);
    end
  end

  assign E        = e_q;
  assign WAKE_ACK = ack_q;
  assign GATED    = gated_q;

`ifdef CG_IDLE_CTRL_STATS_EN
  logic [15:0] evt_cnt_q, evt_cnt_d;
  logic [3:0]  evt_sum;
  logic [16:0] evt_total;

  always_comb begin
    evt_sum = '0;
    for (int unsigned d = 0; d < N_DOM; d++) begin
      evt_sum = evt_sum + 4'((state_q[d] == S_IDLE_CNT) && (state_d[d] == S_GATED));
    end
    evt_total = 17'(evt_cnt_q) + 17'(evt_sum);
    evt_cnt_d = evt_total[16] ? '1 : evt_total[15:0];
  end

  always_ff @(posedge CK) begin
    if (RST) evt_cnt_q <= '0;
    else     evt_cnt_q <= evt_cnt_d;
  end

  assign GATE_EVT_CNT = evt_cnt_q;
`endif

endmodule
